dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data_mem port between the pipeline MEM stage (core) and an
//  external loader/debug port (valid/ready). Core has priority. A starvation
//  counter lets the loader steal one slot by stalling the core for one cycle.
//  A halt request parks the core so the loader owns memory indefinitely.
//  core_stall feeds Haz_unit to freeze enb/enb_2/enb_3/enb_4/count_enb.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width
//  MAX_WAIT  8   loader wait cycles (>=1) before a forced steal
// PORTS
//  cpu_clk     in   1       clock, all state on rising edge
//  reset       in   1       asynchronous, active-high reset
//  core_req    in   1       MEM stage holds a load/store this cycle
//  core_we     in   1       1=store, 0=load
//  core_addr   in   ADDR_W  core address (ALU_OUT_rg3)
//  core_wdata  in   DATA_W  core store data
//  core_func3  in   3       core access size/sign
//  core_rdata  out  DATA_W  load data to stage_4 (same cycle)
//  core_stall  out  1       core access not served; hold pipeline
//  ld_valid    in   1       loader request valid
//  ld_ready    out  1       loader request accepted this cycle
//  ld_we       in   1       loader store
//  ld_addr     in   ADDR_W  loader address
//  ld_wdata    in   DATA_W  loader store data
//  ld_func3    in   3       loader access size
//  ld_rdata    out  DATA_W  loader read data, registered
//  ld_rvalid   out  1       ld_rdata valid (1 cycle after accepted load)
//  halt_req    in   1       request core halt
//  halted      out  1       core parked, loader owns port
//  mem_addr/mem_wdata/mem_we/mem_func3 out  ADDR_W/DATA_W/1/3  to data_mem
//  mem_rdata   in   DATA_W  combinational read data from data_mem
// BEHAVIOUR
//  - Port mux combinational from state+requests; data_mem write on clock edge.
//  - States: RUN, STEAL, HALT. Reset -> RUN, wait_cnt=0, ld_rvalid=0,
//    ld_rdata=0, halted=0. Outputs otherwise combinational (no reset value).
//  - RUN: core_req=1 -> core owns port, ld_ready=0, core_stall=0.
//    core_req=0 & ld_valid -> loader owns port, ld_ready=1, wait_cnt<=0.
//    Neither -> mem_we=0, addr=core_addr.
//    ld_valid & core_req -> wait_cnt++; at wait_cnt==MAX_WAIT-1 next=STEAL.
//  - STEAL (1 cycle): loader owns port, ld_ready=ld_valid, core_stall=core_req,
//    wait_cnt<=0, next=RUN. If ld_valid dropped, slot unused, still 1 cycle.
//  - HALT: core_stall=core_req, halted=1, loader owns port, ld_ready=ld_valid.
//    Exit to RUN the cycle after halt_req=0.
//  - halt_req=1 from any state -> next=HALT; beats STEAL. wait_cnt cleared.
//  - mem_we = owner_we & owner_valid; never writes when owner not requesting.
//  - core_rdata = mem_rdata always. Accepted loader load: ld_rdata<=mem_rdata,
//    ld_rvalid<=1 next cycle; ld_rvalid=0 otherwise. Store: no rvalid.
//  - wait_cnt saturates; width $clog2(MAX_WAIT)+1. Reset mid-STEAL/HALT
//    aborts to RUN; in-flight rvalid dropped.
//  - Stalled core store must not reach memory; pipeline re-presents it.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: outputs stat_stall_cnt[31:0] (cycles with
//  core_stall=1) and stat_ld_cnt[31:0] (loader accepts), saturating at
//  32'hFFFF_FFFF, reset 0. Undefined: both ports present, tied to 0.
// TESTING
//  1 core_req=1 load addr 0x40, ld_valid=0 -> mem_addr=0x40, core_stall=0.
//  2 core_req=0, ld_valid store 0x80<=0xDEADBEEF -> ld_ready=1, mem_we=1,
//    then load 0x80 -> ld_rvalid=1 next cycle, ld_rdata=0xDEADBEEF.
//  3 core_req=1 continuous, ld_valid=1 -> 7 cycles ld_ready=0, 8th cycle
//    STEAL: ld_ready=1, core_stall=1, mem_we follows ld_we; then RUN.
//  4 halt_req=1 with core_req=1 -> next cycle halted=1, core_stall=1;
//    halt_req=0 -> next cycle halted=0, core_stall=0.
//  5 halt_req and steal coincide -> HALT entered, no STEAL cycle.
//  6 reset asserted in STEAL with load accepted -> RUN, ld_rvalid=0 at once.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data_mem port arbiter between the core MEM stage and a loader/debug port.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_func3,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic [2:0]        ld_func3,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    input  logic              halt_req,
    output logic              halted,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       stat_stall_cnt,
    output logic [31:0]       stat_ld_cnt
);
    localparam int CW = $clog2(MAX_WAIT) + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STEAL = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // The steal is scheduled when the incremented count reaches MAX_WAIT-1,
    // so the loader is refused for MAX_WAIT-1 cycles and served on the next.
    localparam logic [CW:0]   STEAL_AT = (CW+1)'(MAX_WAIT - 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT - 1);

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] next_wait;
    logic [CW:0]   wait_inc;
    logic          ld_owner;

    always_comb begin
        ld_owner   = (state != ST_RUN) || (!core_req && ld_valid);
        ld_ready   = ld_owner && ld_valid;
        core_stall = (state != ST_RUN) && core_req;
        halted     = (state == ST_HALT);
        core_rdata = mem_rdata;
        // A stalled core never owns the port, so its store cannot reach memory.
        if (ld_owner) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_func3 = ld_func3;
            mem_we    = ld_we && ld_valid;
        end else begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_func3 = core_func3;
            mem_we    = core_we && core_req;
        end
    end

    always_comb begin
        next_state = ST_RUN;
        next_wait  = wait_cnt;
        wait_inc   = {1'b0, wait_cnt} + 1'b1;
        if (halt_req) begin
            next_state = ST_HALT;
            next_wait  = '0;
        end else if (state == ST_RUN) begin
            if (core_req && ld_valid) begin
                next_wait = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_inc[CW-1:0];
                if (wait_inc >= STEAL_AT) begin
                    next_state = ST_STEAL;
                end
            end else if (ld_valid) begin
                next_wait = '0;
            end
        end else begin
            next_state = ST_RUN;
            next_wait  = '0;
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            ld_rvalid <= 1'b0;
            ld_rdata  <= '0;
        end else begin
            state     <= next_state;
            wait_cnt  <= next_wait;
            ld_rvalid <= ld_ready && !ld_we;
            if (ld_ready && !ld_we) begin
                ld_rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            stat_stall_cnt <= '0;
            stat_ld_cnt    <= '0;
        end else begin
            if (core_stall && (stat_stall_cnt != 32'hFFFF_FFFF)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
            if (ld_ready && (stat_ld_cnt != 32'hFFFF_FFFF)) begin
                stat_ld_cnt <= stat_ld_cnt + 32'd1;
            end
        end
    end
`else
    assign stat_stall_cnt = '0;
    assign stat_ld_cnt    = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;
    logic        cpu_clk;
    logic        reset;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [2:0]  core_func3;
    logic        core_stall;
    logic        ld_valid, ld_ready, ld_we;
    logic [31:0] ld_addr, ld_wdata, ld_rdata;
    logic [2:0]  ld_func3;
    logic        ld_rvalid;
    logic        halt_req, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [2:0]  mem_func3;
    logic [31:0] stat_stall_cnt, stat_ld_cnt;

    logic [31:0] mem [0:255];
    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
        .cpu_clk(cpu_clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_func3(core_func3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_func3(ld_func3),
        .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .halt_req(halt_req), .halted(halted),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_func3(mem_func3), .mem_rdata(mem_rdata),
        .stat_stall_cnt(stat_stall_cnt), .stat_ld_cnt(stat_ld_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge cpu_clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    task automatic next_cycle();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_func3 = 3'b010;
        ld_valid = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_func3 = 3'b010;
        halt_req = 0;
        next_cycle();
        checks++; if (ld_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", ld_rvalid); end
        checks++; if (ld_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", ld_rdata); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (stat_stall_cnt !== 32'h0 || stat_ld_cnt !== 32'h0) begin failures++; $display("FAIL reset_stats got=%h/%h exp=0/0", stat_stall_cnt, stat_ld_cnt); end
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_core_load();
        core_req = 1; core_we = 0; core_addr = 32'h40;
        #1;
        checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL core_addr got=%h exp=40", mem_addr); end
        checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL core_stall got=%b exp=0", core_stall); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL core_ld_ready got=%b exp=0", ld_ready); end
        checks++; if (core_rdata !== 32'hA000_0010) begin failures++; $display("FAIL core_rdata got=%h exp=a0000010", core_rdata); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL core_load_we got=%b exp=0", mem_we); end
        next_cycle();
    endtask

    task automatic test_loader();
        core_req = 0; ld_valid = 1; ld_we = 1; ld_addr = 32'h80; ld_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL ld_store_ready got=%b exp=1", ld_ready); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL ld_store_we got=%b exp=1", mem_we); end
        checks++; if (mem_addr !== 32'h80) begin failures++; $display("FAIL ld_store_addr got=%h exp=80", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ld_store_wdata got=%h exp=deadbeef", mem_wdata); end
        next_cycle();
        ld_we = 0;
        #1;
        checks++; if (ld_rvalid !== 1'b0) begin failures++; $display("FAIL ld_store_no_rvalid got=%b exp=0", ld_rvalid); end
        checks++; if (ld_ready !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL ld_load_accept got=%b/%b exp=1/0", ld_ready, mem_we); end
        next_cycle();
        ld_valid = 0; core_addr = 32'h44;
        #1;
        checks++; if (ld_rvalid !== 1'b1) begin failures++; $display("FAIL ld_rvalid got=%b exp=1", ld_rvalid); end
        checks++; if (ld_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ld_rdata got=%h exp=deadbeef", ld_rdata); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h44) begin failures++; $display("FAIL idle_port got=%b/%h exp=0/44", mem_we, mem_addr); end
        next_cycle();
        checks++; if (ld_rvalid !== 1'b0) begin failures++; $display("FAIL ld_rvalid_drop got=%b exp=0", ld_rvalid); end
    endtask

    task automatic test_steal();
        core_req = 1; core_we = 1; core_addr = 32'h100; core_wdata = 32'h1111_1111;
        ld_valid = 1; ld_we = 1; ld_addr = 32'h84; ld_wdata = 32'hCAFE_F00D;
        for (int i = 1; i <= 7; i++) begin
            #1;
            checks++; if (ld_ready !== 1'b0 || core_stall !== 1'b0) begin failures++; $display("FAIL steal_wait%0d got=%b/%b exp=0/0", i, ld_ready, core_stall); end
            next_cycle();
        end
        #1;
        checks++; if (ld_ready !== 1'b1 || core_stall !== 1'b1) begin failures++; $display("FAIL steal_slot got=%b/%b exp=1/1", ld_ready, core_stall); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h84) begin failures++; $display("FAIL steal_port got=%b/%h exp=1/84", mem_we, mem_addr); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL steal_halted got=%b exp=0", halted); end
        next_cycle();
        #1;
        checks++; if (ld_ready !== 1'b0 || core_stall !== 1'b0 || mem_addr !== 32'h100) begin failures++; $display("FAIL steal_return got=%b/%b/%h exp=0/0/100", ld_ready, core_stall, mem_addr); end
        checks++; if (mem[33] !== 32'hCAFE_F00D) begin failures++; $display("FAIL steal_write got=%h exp=cafef00d", mem[33]); end
        core_req = 0; ld_valid = 0;
        next_cycle();
    endtask

    task automatic test_halt();
        core_req = 1; core_we = 0; core_addr = 32'h200; halt_req = 1;
        #1;
        checks++; if (halted !== 1'b0 || core_stall !== 1'b0) begin failures++; $display("FAIL halt_pre got=%b/%b exp=0/0", halted, core_stall); end
        next_cycle();
        core_we = 1; core_wdata = 32'h5555_5555;
        #1;
        checks++; if (halted !== 1'b1 || core_stall !== 1'b1) begin failures++; $display("FAIL halt_on got=%b/%b exp=1/1", halted, core_stall); end
        checks++; if (mem_we !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL halt_block_store got=%b/%b exp=0/0", mem_we, ld_ready); end
        ld_valid = 1; ld_we = 0; ld_addr = 32'h80; halt_req = 0;
        #1;
        checks++; if (ld_ready !== 1'b1 || mem_addr !== 32'h80) begin failures++; $display("FAIL halt_ld got=%b/%h exp=1/80", ld_ready, mem_addr); end
        next_cycle();
        ld_valid = 0; core_we = 0;
        #1;
        checks++; if (halted !== 1'b0 || core_stall !== 1'b0) begin failures++; $display("FAIL halt_exit got=%b/%b exp=0/0", halted, core_stall); end
        checks++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL halt_rdata got=%b/%h exp=1/deadbeef", ld_rvalid, ld_rdata); end
        checks++; if (mem[128] !== 32'hA000_0080) begin failures++; $display("FAIL halt_store_leak got=%h exp=a0000080", mem[128]); end
        next_cycle();
    endtask

    task automatic test_halt_beats_steal();
        core_req = 1; core_we = 0; core_addr = 32'h40;
        ld_valid = 1; ld_we = 0; ld_addr = 32'h80;
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) halt_req = 1;
            #1;
            checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL hbs_wait%0d got=%b exp=0", i, ld_ready); end
            next_cycle();
        end
        halt_req = 0;
        #1;
        checks++; if (halted !== 1'b1 || core_stall !== 1'b1 || ld_ready !== 1'b1) begin failures++; $display("FAIL hbs_halt got=%b/%b/%b exp=1/1/1", halted, core_stall, ld_ready); end
        next_cycle();
        #1;
        checks++; if (halted !== 1'b0 || core_stall !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL hbs_exit got=%b/%b/%b exp=0/0/0", halted, core_stall, ld_ready); end
        next_cycle();
    endtask

    task automatic test_reset_in_steal();
        core_req = 0; ld_valid = 1; ld_we = 0; ld_addr = 32'h80;
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL ris_accept got=%b exp=1", ld_ready); end
        next_cycle();
        core_req = 1;
        for (int i = 1; i <= 7; i++) next_cycle();
        #1;
        checks++; if (ld_ready !== 1'b1 || core_stall !== 1'b1) begin failures++; $display("FAIL ris_steal got=%b/%b exp=1/1", ld_ready, core_stall); end
        reset = 1;
        #1;
        checks++; if (ld_ready !== 1'b0 || core_stall !== 1'b0 || ld_rvalid !== 1'b0) begin failures++; $display("FAIL ris_abort got=%b/%b/%b exp=0/0/0", ld_ready, core_stall, ld_rvalid); end
        next_cycle();
        checks++; if (ld_rvalid !== 1'b0 || ld_rdata !== 32'h0) begin failures++; $display("FAIL ris_rvalid got=%b/%h exp=0/0", ld_rvalid, ld_rdata); end
        reset = 0; core_req = 0; ld_valid = 0;
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        test_reset();
        test_core_load();
        test_loader();
        test_steal();
        test_halt();
        test_halt_beats_steal();
        test_reset_in_steal();
`ifndef DMEM_ARB_STATS_EN
        checks++; if (stat_stall_cnt !== 32'h0 || stat_ld_cnt !== 32'h0) begin failures++; $display("FAIL stats_tied got=%h/%h exp=0/0", stat_stall_cnt, stat_ld_cnt); end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
